// File: rtl/stdio_arbiter.sv
// Round-robin arbiter merging N val/rdy/data producers into one registered output stream.
// A grant is held for up to MAX_BURST words; every grant change costs one idle cycle.
module stdio_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int WIDTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_val_i,
    output logic [N-1:0]         req_rdy_o,
    input  logic [N*WIDTH-1:0]   req_data_i,
    output logic                 out_val_o,
    input  logic                 out_rdy_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [N-1:0]         grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_reg, state_next;
    logic [N-1:0]      grant_reg, grant_next;
    logic [PW-1:0]     gidx_reg, gidx_next;
    logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]     burst_cnt_reg, burst_cnt_next;
    logic              out_val_reg, out_val_next;
    logic [WIDTH-1:0]  out_data_reg, out_data_next;

    logic              load_en;
    logic              in_xfer;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [WIDTH-1:0]  req_data_arr [N];

    assign load_en = ~out_val_reg | out_rdy_i;
    assign in_xfer = (state_reg == BURST) && req_val_i[gidx_reg] && load_en;

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign req_data_arr[gi] = req_data_i[gi*WIDTH +: WIDTH];
        assign req_rdy_o[gi]    = (state_reg == BURST) && grant_reg[gi] && load_en;
    end

    // Scan from the farthest offset back to rr_ptr so the closest valid index wins.
    always_comb begin
        int c;
        pick_found = 1'b0;
        pick_idx   = rr_ptr_reg;
        for (int i = N - 1; i >= 0; i--) begin
            c = int'(rr_ptr_reg) + i;
            if (c >= N) c = c - N;
            if (req_val_i[c]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(c);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        gidx_next      = gidx_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        out_val_next   = out_val_reg;
        out_data_next  = out_data_reg;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    gidx_next            = pick_idx;
                    burst_cnt_next       = '0;
                    state_next           = BURST;
                end
            end
            BURST: begin
                if (!req_val_i[gidx_reg] ||
                    (load_en && (burst_cnt_reg + CW'(1) == CW'(MAX_BURST)))) begin
                    grant_next  = '0;
                    rr_ptr_next = (gidx_reg == PW'(N - 1)) ? '0 : gidx_reg + PW'(1);
                    state_next  = IDLE;
                end
                if (in_xfer) begin
                    burst_cnt_next = burst_cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (in_xfer) begin
            out_data_next = req_data_arr[gidx_reg];
            out_val_next  = 1'b1;
        end else if (out_val_reg && out_rdy_i) begin
            out_val_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            gidx_reg      <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            out_val_reg   <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            gidx_reg      <= gidx_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            out_val_reg   <= out_val_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign grant_o    = grant_reg;
    assign out_val_o  = out_val_reg;
    assign out_data_o = out_data_reg;

endmodule

// File: tb/tb_stdio_arbiter.sv
// Bench for stdio_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance share stimulus and are
// compared every cycle against a transaction-level ownership model, plus directed scenarios.
module tb_stdio_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req_val;
    logic [N*W-1:0]   req_data;
    logic             out_rdy;
    logic [N-1:0]     rdy0, gnt0, rdy1, gnt1;
    logic             oval0, oval1;
    logic [W-1:0]     odata0, odata1;

    stdio_arbiter #(.N(N), .MAX_BURST(4), .WIDTH(W)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_val_i(req_val), .req_rdy_o(rdy0),
        .req_data_i(req_data), .out_val_o(oval0), .out_rdy_i(out_rdy),
        .out_data_o(odata0), .grant_o(gnt0)
    );

    stdio_arbiter #(.N(N), .MAX_BURST(1), .WIDTH(W)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_val_i(req_val), .req_rdy_o(rdy1),
        .req_data_i(req_data), .out_val_o(oval1), .out_rdy_i(out_rdy),
        .out_data_o(odata1), .grant_o(gnt1)
    );

    int total = 0;
    int bad   = 0;

    // Model: who owns the stream (-1 = nobody), words sent in this grant, next scan start,
    // and the content of the output register.
    int         m_owner [2];
    int         m_sent  [2];
    int         m_ptr   [2];
    bit         m_oval  [2];
    logic [W-1:0] m_odata [2];
    int         mb [2] = '{4, 1};

    logic [W-1:0] got0 [$];
    logic [W-1:0] got1 [$];
    int           cnt [N];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_rdy(int m);
        logic [N-1:0] r = '0;
        if (m_owner[m] >= 0 && (!m_oval[m] || out_rdy)) r[m_owner[m]] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] exp_gnt(int m);
        logic [N-1:0] r = '0;
        if (m_owner[m] >= 0) r[m_owner[m]] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] qget0(int j);
        return (j < got0.size()) ? got0[j] : 'x;
    endfunction

    function automatic logic [W-1:0] qget1(int j);
        return (j < got1.size()) ? got1[j] : 'x;
    endfunction

    task automatic model_edge(int m);
        int  o;
        bit  le;
        bit  moved;
        if (rst) begin
            m_owner[m] = -1; m_sent[m] = 0; m_ptr[m] = 0;
            m_oval[m] = 1'b0; m_odata[m] = '0;
            return;
        end
        o     = m_owner[m];
        le    = !m_oval[m] || out_rdy;
        moved = (o >= 0) && req_val[o] && le;
        if (moved) begin
            m_odata[m] = req_data[o*W +: W];
            m_oval[m]  = 1'b1;
        end else if (m_oval[m] && out_rdy) begin
            m_oval[m] = 1'b0;
        end
        if (o < 0) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr[m] + i) % N;
                if (req_val[c]) begin
                    m_owner[m] = c;
                    m_sent[m]  = 0;
                    break;
                end
            end
        end else if (!req_val[o]) begin
            m_owner[m] = -1;
            m_ptr[m]   = (o + 1) % N;
        end else if (moved) begin
            m_sent[m]++;
            if (m_sent[m] == mb[m]) begin
                m_owner[m] = -1;
                m_ptr[m]   = (o + 1) % N;
            end
        end
    endtask

    // One clock: check ready before the edge, advance the model, check registers after it.
    task automatic step();
        logic [N-1:0] x0;
        #1;
        chk("rdy0", rdy0, exp_rdy(0));
        chk("rdy1", rdy1, exp_rdy(1));
        x0 = req_val & rdy0;
        for (int k = 0; k < N; k++) if (x0[k]) cnt[k]++;
        if (oval0 && out_rdy) begin
            got0.push_back(odata0);
            $display("t=%0t out0 data=%h grant=%b", $time, odata0, gnt0);
        end
        if (oval1 && out_rdy) got1.push_back(odata1);
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        chk("gnt0", gnt0, exp_gnt(0));
        chk("oval0", oval0, m_oval[0]);
        chk("odata0", odata0, m_odata[0]);
        chk("gnt1", gnt1, exp_gnt(1));
        chk("oval1", oval1, m_oval[1]);
        chk("odata1", odata1, m_odata[1]);
    endtask

    task automatic reset_all();
        rst = 1'b1; req_val = '0; out_rdy = 1'b1;
        step();
        rst = 1'b0;
        got0.delete(); got1.delete();
        for (int k = 0; k < N; k++) cnt[k] = 0;
    endtask

    task automatic drain();
        req_val = '0; out_rdy = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        logic [W-1:0] held;
        int           stall;
        logic [W-1:0] e;

        rst = 1'b1; req_val = '0; req_data = '0; out_rdy = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_sent[m] = 0; m_ptr[m] = 0; m_oval[m] = 0; m_odata[m] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset_all();

        // Single requester 2 streams 1..6
        for (int t = 0; t < 40 && cnt[2] < 6; t++) begin
            req_val  = 4'b0100;
            req_data = '0;
            req_data[2*W +: W] = W'(cnt[2] + 1);
            step();
            if (t == 0) chk("lat_1cyc", oval0, 0);
            if (t == 1) chk("lat_2cyc", oval0, 1);
        end
        drain();
        chk("s1_count", got0.size(), 6);
        for (int j = 0; j < 6; j++) chk("s1_word", qget0(j), j + 1);

        // All four requesters valid: bursts of 4 in order, then wrap to 0
        reset_all();
        for (int t = 0; t < 80 && got0.size() < 17; t++) begin
            req_val = 4'b1111;
            for (int k = 0; k < N; k++) req_data[k*W +: W] = W'(k * 256 + cnt[k]);
            step();
        end
        drain();
        for (int j = 0; j < 17; j++) begin
            e = (j < 16) ? W'((j / 4) * 256 + (j % 4)) : W'(4);
            chk("s3_word", qget0(j), e);
        end

        // Backpressure during a requester 1 burst
        reset_all();
        held = '0; stall = 0;
        for (int t = 0; t < 60 && cnt[1] < 4; t++) begin
            req_val  = 4'b0010;
            req_data = '0;
            req_data[W +: W] = W'(16'h0100 + cnt[1]);
            if (cnt[1] == 2 && stall < 5) begin
                out_rdy = 1'b0;
                stall++;
            end else begin
                out_rdy = 1'b1;
            end
            step();
            if (!out_rdy) begin
                chk("s4_rdy_stall", rdy0[1], 0);
                chk("s4_hold", odata0, held);
            end
            held = odata0;
        end
        chk("s4_release", gnt0, 4'b0000);
        drain();
        chk("s4_count", got0.size(), 4);
        for (int j = 0; j < 4; j++) chk("s4_word", qget0(j), 16'h0100 + j);

        // Early release of requester 3 while requester 0 waits
        reset_all();
        req_val = 4'b1000;
        req_data = '0;
        step();
        for (int t = 0; t < 20 && cnt[3] < 2; t++) begin
            req_val = 4'b1001;
            req_data[3*W +: W] = W'(16'h0300 + cnt[3]);
            req_data[0 +: W]   = W'(cnt[0]);
            step();
        end
        req_val = 4'b0001;
        step();
        chk("s5_release", gnt0, 4'b0000);
        step();
        chk("s5_next", gnt0, 4'b0001);
        drain();
        chk("s5_words3", cnt[3], 2);

        // Reset while the output register holds a word
        reset_all();
        out_rdy = 1'b0;
        req_val = 4'b0010;
        for (int t = 0; t < 10 && !oval0; t++) step();
        chk("s6_val_before", oval0, 1);
        rst = 1'b1;
        step();
        chk("s6_val_after", oval0, 0);
        chk("s6_gnt_after", gnt0, 4'b0000);
        rst = 1'b0; req_val = 4'b1111; out_rdy = 1'b1;
        step();
        chk("s6_restart", gnt0, 4'b0001);
        drain();

        // MAX_BURST=1 instance alternates between requesters 0 and 1
        reset_all();
        req_data = '0;
        req_data[W +: W] = 16'h0100;
        req_val = 4'b0011;
        for (int t = 0; t < 40 && got1.size() < 4; t++) step();
        drain();
        for (int j = 0; j < 4; j++) chk("s7_word", qget1(j), (j % 2) ? 16'h0100 : 16'h0000);

        // Randomized traffic with stalls and occasional resets
        for (int t = 0; t < 400; t++) begin
            rst      = ($urandom_range(0, 49) == 0);
            req_val  = N'($urandom);
            req_data = {$urandom, $urandom};
            out_rdy  = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
